// File: rtl/seq_detect_pkg.sv
// Shared state encoding and parameter limits for the serial pattern detector.
// Imported by the detector, its interface and the bench.
package seq_detect_pkg;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 8;
    localparam int CNT_W_MIN = 1;
    localparam int CNT_W_MAX = 8;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        FILL  = 2'b01,
        ARMED = 2'b10,
        BAD   = 2'b11
    } state_t;

endpackage

// File: rtl/seq_detect_if.sv
// Serial data/control bundle between a bit source and the detector.
// The master drives the stream; the slave reports matches and count.
interface seq_detect_if #(
    parameter int WIDTH = 3,
    parameter int CNT_W = 2
);
    import seq_detect_pkg::*;

    logic             in;
    logic             en;
    logic             clr;
    logic [WIDTH-1:0] pattern;
    logic             match;
    logic [CNT_W-1:0] out;
    state_t           state;

    modport master (
        output in, en, clr, pattern,
        input  match, out, state
    );

    modport slave (
        input  in, en, clr, pattern,
        output match, out, state
    );

endinterface

// File: rtl/seq_detect_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] value
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            value <= '0;
        end else if (clr) begin
            value <= '0;
        end else if (inc && (value != '1)) begin
            value <= value + W'(1);
        end
    end

endmodule

// File: rtl/seq_detect.sv
// Serial pattern detector: shifts qualified bits into a history window
// and pulses match when a full window equals the pattern.
module seq_detect
    import seq_detect_pkg::*;
#(
    parameter int WIDTH   = 3,
    parameter int CNT_W   = 2,
    parameter int OVERLAP = 1
) (
    input logic         clk,
    input logic         rst,
    seq_detect_if.slave bus
);

    localparam int            FW   = $clog2(WIDTH + 1);
    localparam logic [FW-1:0] FULL = FW'(WIDTH);

    state_t           st_q, st_d;
    logic [FW-1:0]    fill_q, fill_d;
    logic [WIDTH-1:0] hist_q, hist_d;
    logic             match_q, match_d;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st_q    <= EMPTY;
            fill_q  <= '0;
            hist_q  <= '0;
            match_q <= 1'b0;
        end else begin
            st_q    <= st_d;
            fill_q  <= fill_d;
            hist_q  <= hist_d;
            match_q <= match_d;
        end
    end

    always_comb begin
        st_d    = st_q;
        fill_d  = fill_q;
        hist_d  = hist_q;
        match_d = 1'b0;
        if (bus.clr) begin
            st_d   = EMPTY;
            fill_d = '0;
            hist_d = '0;
        end else if (st_q == BAD) begin
            st_d   = EMPTY;
            fill_d = '0;
        end else if (bus.en) begin
            hist_d = {hist_q[WIDTH-2:0], bus.in};
            fill_d = (fill_q == FULL) ? FULL : fill_q + FW'(1);
            if (st_q == EMPTY) begin
                st_d = FILL;
            end else if (st_q == FILL) begin
                st_d = (fill_d == FULL) ? ARMED : FILL;
            end else begin
                st_d = ARMED;
            end
            match_d = (st_d == ARMED) && (hist_d == bus.pattern);
            // Non-overlapping mode forces WIDTH fresh bits per match
            if (match_d && (OVERLAP == 0)) begin
                st_d   = EMPTY;
                fill_d = '0;
            end
        end
    end

    sat_counter #(
        .W(CNT_W)
    ) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (bus.clr),
        .inc  (match_d),
        .value(cnt)
    );

    assign bus.match = match_q;
    assign bus.out   = cnt;
    assign bus.state = st_q;

endmodule

// File: tb/tb_seq_detect.sv
// Bench: overlapping and non-overlapping detectors on one stream,
// checked every cycle against a window/bit-count model.
module tb_seq_detect;
    import seq_detect_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_r = 1'b0;
    logic       en_r = 1'b0;
    logic       clr_r = 1'b0;
    logic [2:0] pat_r = 3'b101;

    int n_chk = 0;
    int n_pass = 0;

    int nv[2];
    int win[2];
    int cnt[2];
    bit mx[2];

    seq_detect_if #(.WIDTH(3), .CNT_W(2)) if0 ();
    seq_detect_if #(.WIDTH(3), .CNT_W(2)) if1 ();

    assign if0.in = in_r;
    assign if0.en = en_r;
    assign if0.clr = clr_r;
    assign if0.pattern = pat_r;
    assign if1.in = in_r;
    assign if1.en = en_r;
    assign if1.clr = clr_r;
    assign if1.pattern = pat_r;

    seq_detect #(.WIDTH(3), .CNT_W(2), .OVERLAP(1)) u_ov (
        .clk(clk),
        .rst(rst),
        .bus(if0)
    );

    seq_detect #(.WIDTH(3), .CNT_W(2), .OVERLAP(0)) u_no (
        .clk(clk),
        .rst(rst),
        .bus(if1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask

    function automatic int exp_state(input int m);
        if (nv[m] == 0) return 0;
        if (nv[m] < 3) return 1;
        return 2;
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            nv[m] = 0;
            win[m] = 0;
            cnt[m] = 0;
            mx[m] = 1'b0;
        end
    endtask

    task automatic cyc(input bit e, input bit b, input bit c);
        en_r = e;
        in_r = b;
        clr_r = c;
        @(posedge clk);
        for (int m = 0; m < 2; m++) begin
            mx[m] = 1'b0;
            if (c) begin
                nv[m] = 0;
                win[m] = 0;
                cnt[m] = 0;
            end else if (e) begin
                nv[m] = (nv[m] < 3) ? nv[m] + 1 : 3;
                win[m] = (win[m] * 2 + int'(b)) % 8;
                if (nv[m] >= 3 && win[m] == int'(pat_r)) begin
                    mx[m] = 1'b1;
                    if (cnt[m] < 3) cnt[m]++;
                    if (m == 1) nv[m] = 0;
                end
            end
        end
        @(negedge clk);
        chk("ov.match", int'(if0.match), int'(mx[0]));
        chk("ov.out", int'(if0.out), cnt[0]);
        chk("ov.state", int'(if0.state), exp_state(0));
        chk("no.match", int'(if1.match), int'(mx[1]));
        chk("no.out", int'(if1.out), cnt[1]);
        chk("no.state", int'(if1.state), exp_state(1));
    endtask

    task automatic do_rst();
        #1 rst = 1'b0;
        #1;
        chk("rst.ov.state", int'(if0.state), 0);
        chk("rst.ov.out", int'(if0.out), 0);
        chk("rst.no.match", int'(if1.match), 0);
        model_reset();
        #1 rst = 1'b1;
    endtask

    initial begin
        int exp_out[7];
        int mc;
        bit [2:0] pb;
        exp_out = '{0, 0, 1, 2, 3, 3, 3};
        model_reset();
        #2;
        chk("init.ov.state", int'(if0.state), 0);
        chk("init.ov.match", int'(if0.match), 0);
        chk("init.ov.out", int'(if0.out), 0);
        chk("init.no.state", int'(if1.state), 0);
        @(negedge clk);
        rst = 1'b1;

        // 1,0,1,0,1 against 101
        pat_r = 3'b101;
        cyc(1, 1, 0);
        cyc(1, 0, 0);
        cyc(1, 1, 0);
        chk("s101.ov.m3", int'(if0.match), 1);
        chk("s101.no.m3", int'(if1.match), 1);
        chk("s101.no.st3", int'(if1.state), 0);
        cyc(1, 0, 0);
        cyc(1, 1, 0);
        chk("s101.ov.m5", int'(if0.match), 1);
        chk("s101.no.m5", int'(if1.match), 0);
        chk("s101.ov.out", int'(if0.out), 2);
        chk("s101.no.out", int'(if1.out), 1);

        // seven ones against 111, count saturates at 3
        do_rst();
        pat_r = 3'b111;
        mc = 0;
        for (int k = 0; k < 7; k++) begin
            cyc(1, 1, 0);
            mc += int'(if0.match);
            chk("s111.ov.out", int'(if0.out), exp_out[k]);
        end
        chk("s111.ov.pulses", mc, 5);

        // gap with en low and in toggling
        do_rst();
        pat_r = 3'b101;
        cyc(1, 1, 0);
        cyc(1, 0, 0);
        mc = 0;
        for (int k = 0; k < 4; k++) begin
            cyc(0, k[0], 0);
            mc += int'(if0.match);
        end
        chk("gap.ov.quiet", mc, 0);
        cyc(1, 1, 0);
        chk("gap.ov.final", int'(if0.match), 1);

        // reset mid-sequence discards 1,0
        do_rst();
        cyc(1, 1, 0);
        cyc(1, 0, 0);
        do_rst();
        cyc(1, 1, 0);
        chk("mrst.ov.match", int'(if0.match), 0);
        chk("mrst.ov.state", int'(if0.state), 1);
        cyc(1, 0, 0);
        cyc(1, 1, 0);
        chk("mrst.ov.rematch", int'(if0.match), 1);

        // clear wins on the completing edge
        do_rst();
        cyc(1, 1, 0);
        cyc(1, 0, 0);
        cyc(1, 1, 1);
        chk("clr.ov.match", int'(if0.match), 0);
        chk("clr.ov.out", int'(if0.out), 0);
        chk("clr.ov.state", int'(if0.state), 0);

        // every 3-bit pattern matches exactly once on its own bits
        for (int p = 0; p < 8; p++) begin
            do_rst();
            pb = 3'(p);
            pat_r = pb;
            mc = 0;
            for (int k = 2; k >= 0; k--) begin
                cyc(1, pb[k], 0);
                mc += int'(if0.match);
            end
            chk("sweep.ov.once", mc, 1);
        end

        // random stream, occasional clear and pattern change
        do_rst();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 19) == 0) pat_r = 3'($urandom_range(0, 7));
            cyc($urandom_range(0, 99) < 75,
                1'($urandom_range(0, 1)),
                $urandom_range(0, 99) < 3);
            if ($urandom_range(0, 149) == 0) do_rst();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
